// File: rtl/melody_if.sv
// Host-side control and tone-output bundle for the melody sequencer.
interface melody_if;
  logic       Wr_en;
  logic [3:0] Wr_addr;
  logic [5:0] Wr_data;
  logic [3:0] Last_idx;
  logic       Loop;
  logic       Start;
  logic       Stop;
  logic [2:0] Tone_sel;
  logic       Tone_en;
  logic       Busy;
  logic [3:0] Note_idx;
  logic       Done;

  modport master (
    output Wr_en, Wr_addr, Wr_data, Last_idx, Loop, Start, Stop,
    input  Tone_sel, Tone_en, Busy, Note_idx, Done
  );

  modport slave (
    input  Wr_en, Wr_addr, Wr_data, Last_idx, Loop, Start, Stop,
    output Tone_sel, Tone_en, Busy, Note_idx, Done
  );
endinterface

// File: rtl/melody_sequencer.sv
// Steps through a 16-entry note table, holding each tone for 1..4 beats with an
// optional silent gap after every entry; drives tone select/enable for the audio path.
module melody_sequencer #(
  parameter int unsigned NOTE_TICKS = 25_000_000,
  parameter int unsigned GAP_TICKS  = 2_500_000,
  parameter int unsigned CNT_W      = 32
) (
  input logic     Clk,
  input logic     Reset_n,
  melody_if.slave bus
);

  localparam int unsigned DEPTH = 16;
  localparam logic [CNT_W-1:0] NOTE_T  = CNT_W'(NOTE_TICKS);
  localparam logic [CNT_W-1:0] GAP_END = CNT_W'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       beats_q, beats_d;
  logic [3:0]       last_q, last_d;
  logic [3:0]       idx_q, idx_d;
  logic [2:0]       tone_sel_q, tone_sel_d;
  logic             tone_en_q, tone_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [5:0]       table_q [DEPTH];

  logic [CNT_W-1:0] play_end;
  logic             end_entry;
  logic             fetch;
  logic [3:0]       fetch_idx;
  logic [5:0]       entry;

  assign play_end = CNT_W'(beats_q) * NOTE_T - CNT_W'(1);

  // Note table: host writes at any time; reads happen only at fetch, so a same-edge write returns old data
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else if (bus.Wr_en) begin
      table_q[bus.Wr_addr] <= bus.Wr_data;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      beats_q    <= '0;
      last_q     <= '0;
      idx_q      <= '0;
      tone_sel_q <= '0;
      tone_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beats_q    <= beats_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      tone_sel_q <= tone_sel_d;
      tone_en_q  <= tone_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    beats_d    = beats_q;
    last_d     = last_q;
    idx_d      = idx_q;
    tone_sel_d = tone_sel_q;
    tone_en_d  = tone_en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    end_entry  = 1'b0;
    fetch      = 1'b0;
    fetch_idx  = idx_q;
    entry      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.Start && !bus.Stop) begin
          last_d    = bus.Last_idx;
          busy_d    = 1'b1;
          fetch     = 1'b1;
          fetch_idx = '0;
        end
      end
      S_PLAY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == play_end) begin
          if (GAP_TICKS != 0) begin
            state_d   = S_GAP;
            tone_en_d = 1'b0;
            cnt_d     = '0;
          end else begin
            end_entry = 1'b1;
          end
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == GAP_END) end_entry = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Loop is sampled live here, Last_idx only from the Start-time latch
    if (end_entry) begin
      if (idx_q != last_q) begin
        fetch     = 1'b1;
        fetch_idx = 4'(idx_q + 4'd1);
      end else if (bus.Loop) begin
        fetch     = 1'b1;
        fetch_idx = '0;
      end else begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        tone_en_d = 1'b0;
        done_d    = 1'b1;
        cnt_d     = '0;
      end
    end

    if (fetch) begin
      entry      = table_q[fetch_idx];
      state_d    = S_PLAY;
      idx_d      = fetch_idx;
      tone_sel_d = entry[2:0];
      tone_en_d  = ~entry[5];
      beats_d    = 3'(entry[4:3]) + 3'd1;
      cnt_d      = '0;
    end

    // Abort wins over everything else once playback is active
    if (bus.Stop && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      idx_d      = idx_q;
      tone_sel_d = tone_sel_q;
      beats_d    = beats_q;
      tone_en_d  = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      cnt_d      = '0;
    end
  end

  assign bus.Tone_sel = tone_sel_q;
  assign bus.Tone_en  = tone_en_q;
  assign bus.Busy     = busy_q;
  assign bus.Note_idx = idx_q;
  assign bus.Done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: NOTE_TICKS=4 with a 2-cycle gap, plus a gapless instance.
module tb_melody_sequencer;

  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  melody_if bus ();
  melody_if bus0 ();

  melody_sequencer #(.NOTE_TICKS(4), .GAP_TICKS(2), .CNT_W(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus.slave)
  );

  melody_sequencer #(.NOTE_TICKS(4), .GAP_TICKS(0), .CNT_W(8)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus0.slave)
  );

  int checks = 0;
  int fails  = 0;

  logic [9:0] obs, exp;
  logic       eb, ee, ed;
  logic [2:0] es;
  logic [3:0] ei;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [5:0] d);
    bus.Wr_en = 1'b1; bus.Wr_addr = a; bus.Wr_data = d;
    tick();
    bus.Wr_en = 1'b0;
  endtask

  task automatic wr0(input logic [3:0] a, input logic [5:0] d);
    bus0.Wr_en = 1'b1; bus0.Wr_addr = a; bus0.Wr_data = d;
    tick();
    bus0.Wr_en = 1'b0;
  endtask

  task automatic test_reset();
    obs = {bus.Busy, bus.Tone_en, bus.Tone_sel, bus.Note_idx, bus.Done};
    checks++;
    if (obs !== 10'b0) begin fails++; $display("FAIL reset_state got=%b exp=%b", obs, 10'b0); end
    obs = {bus0.Busy, bus0.Tone_en, bus0.Tone_sel, bus0.Note_idx, bus0.Done};
    checks++;
    if (obs !== 10'b0) begin fails++; $display("FAIL reset_state_nogap got=%b exp=%b", obs, 10'b0); end
    Reset_n = 1'b1;
    tick();

    wr(4'd0, 6'b0_01_110); wr(4'd1, 6'b0_00_011); wr(4'd2, 6'b1_00_101);
    bus.Last_idx = 4'd2; bus.Loop = 1'b0;
    bus.Start = 1'b1; tick(); bus.Start = 1'b0; tick();
    obs = {bus.Busy, bus.Tone_en, bus.Tone_sel, bus.Note_idx, bus.Done};
    checks++;
    if (obs !== {1'b1, 1'b1, 3'd6, 4'd0, 1'b0}) begin
      fails++; $display("FAIL pre_reset_play got=%b exp=%b", obs, {1'b1, 1'b1, 3'd6, 4'd0, 1'b0});
    end
    #1 Reset_n = 1'b0;
    #1;
    obs = {bus.Busy, bus.Tone_en, bus.Tone_sel, bus.Note_idx, bus.Done};
    checks++;
    if (obs !== 10'b0) begin fails++; $display("FAIL async_reset got=%b exp=%b", obs, 10'b0); end
    #2 Reset_n = 1'b1;
    tick();

    // Table must be cleared: three zero entries play tone 0 for one beat each
    bus.Start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 0) bus.Start = 1'b0;
      if (c < 18) begin
        eb = 1'b1; ee = ((c % 6) < 4); es = 3'd0; ei = 4'(c / 6); ed = 1'b0;
      end else begin
        eb = 1'b0; ee = 1'b0; es = 3'd0; ei = 4'd2; ed = (c == 18);
      end
      exp = {eb, ee, es, ei, ed};
      obs = {bus.Busy, bus.Tone_en, bus.Tone_sel, bus.Note_idx, bus.Done};
      checks++;
      if (obs !== exp) begin fails++; $display("FAIL table_cleared c=%0d got=%b exp=%b", c, obs, exp); end
    end
  endtask

  task automatic test_basic();
    wr(4'd0, 6'b0_00_000); wr(4'd1, 6'b0_01_101);
    bus.Last_idx = 4'd1; bus.Loop = 1'b0;
    bus.Start = 1'b1;
    for (int c = 0; c < 18; c++) begin
      tick();
      if (c == 0) bus.Start = 1'b0;
      eb = 1'b1; ed = 1'b0;
      if (c < 4)       begin ee = 1'b1; es = 3'd0; ei = 4'd0; end
      else if (c < 6)  begin ee = 1'b0; es = 3'd0; ei = 4'd0; end
      else if (c < 14) begin ee = 1'b1; es = 3'd5; ei = 4'd1; end
      else if (c < 16) begin ee = 1'b0; es = 3'd5; ei = 4'd1; end
      else begin eb = 1'b0; ee = 1'b0; es = 3'd5; ei = 4'd1; ed = (c == 16); end
      exp = {eb, ee, es, ei, ed};
      obs = {bus.Busy, bus.Tone_en, bus.Tone_sel, bus.Note_idx, bus.Done};
      checks++;
      if (obs !== exp) begin fails++; $display("FAIL basic c=%0d got=%b exp=%b", c, obs, exp); end
    end
  endtask

  task automatic test_rest_loop();
    wr(4'd0, 6'b1_00_011);
    bus.Last_idx = 4'd0; bus.Loop = 1'b1;
    bus.Start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c == 0) bus.Start = 1'b0;
      if (c < 18) begin eb = 1'b1; ed = 1'b0; end
      else begin eb = 1'b0; ed = (c == 18); end
      exp = {eb, 1'b0, 3'd3, 4'd0, ed};
      obs = {bus.Busy, bus.Tone_en, bus.Tone_sel, bus.Note_idx, bus.Done};
      checks++;
      if (obs !== exp) begin fails++; $display("FAIL rest_loop c=%0d got=%b exp=%b", c, obs, exp); end
      if (c == 14) bus.Loop = 1'b0;
    end
  endtask

  task automatic test_stop_start();
    bus.Start = 1'b1; bus.Stop = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      exp = {1'b0, 1'b0, 3'd3, 4'd0, 1'b0};
      obs = {bus.Busy, bus.Tone_en, bus.Tone_sel, bus.Note_idx, bus.Done};
      checks++;
      if (obs !== exp) begin fails++; $display("FAIL start_and_stop c=%0d got=%b exp=%b", c, obs, exp); end
    end
    bus.Start = 1'b0; bus.Stop = 1'b0;

    // Start held while busy must not restart the 16-cycle note
    wr(4'd0, 6'b0_11_010);
    bus.Last_idx = 4'd0; bus.Loop = 1'b0;
    bus.Start = 1'b1;
    for (int c = 0; c < 19; c++) begin
      tick();
      if (c < 16)      exp = {1'b1, 1'b1, 3'd2, 4'd0, 1'b0};
      else if (c < 18) exp = {1'b1, 1'b0, 3'd2, 4'd0, 1'b0};
      else             exp = {1'b0, 1'b0, 3'd2, 4'd0, 1'b1};
      obs = {bus.Busy, bus.Tone_en, bus.Tone_sel, bus.Note_idx, bus.Done};
      checks++;
      if (obs !== exp) begin fails++; $display("FAIL start_while_busy c=%0d got=%b exp=%b", c, obs, exp); end
      if (c == 5) bus.Start = 1'b0;
    end

    bus.Start = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c == 0) bus.Start = 1'b0;
      if (c < 3) exp = {1'b1, 1'b1, 3'd2, 4'd0, 1'b0};
      else       exp = {1'b0, 1'b0, 3'd2, 4'd0, 1'b0};
      obs = {bus.Busy, bus.Tone_en, bus.Tone_sel, bus.Note_idx, bus.Done};
      checks++;
      if (obs !== exp) begin fails++; $display("FAIL stop_mid_play c=%0d got=%b exp=%b", c, obs, exp); end
      if (c == 2) bus.Stop = 1'b1;
      if (c == 3) bus.Stop = 1'b0;
    end
  endtask

  task automatic test_live_write();
    wr(4'd0, 6'b0_00_001); wr(4'd1, 6'b0_00_010);
    bus.Last_idx = 4'd1; bus.Loop = 1'b0;
    bus.Start = 1'b1;
    for (int c = 0; c < 26; c++) begin
      tick();
      if (c == 0) bus.Start = 1'b0;
      if (c < 4)       exp = {1'b1, 1'b1, 3'd1, 4'd0, 1'b0};
      else if (c < 6)  exp = {1'b1, 1'b0, 3'd1, 4'd0, 1'b0};
      else if (c < 22) exp = {1'b1, 1'b1, 3'd7, 4'd1, 1'b0};
      else if (c < 24) exp = {1'b1, 1'b0, 3'd7, 4'd1, 1'b0};
      else             exp = {1'b0, 1'b0, 3'd7, 4'd1, (c == 24)};
      obs = {bus.Busy, bus.Tone_en, bus.Tone_sel, bus.Note_idx, bus.Done};
      checks++;
      if (obs !== exp) begin fails++; $display("FAIL live_write c=%0d got=%b exp=%b", c, obs, exp); end
      if (c == 1) begin bus.Wr_en = 1'b1; bus.Wr_addr = 4'd1; bus.Wr_data = 6'b0_11_111; end
      if (c == 2) bus.Wr_en = 1'b0;
    end

    // Write lands on entry 1's fetch edge: old tone 5 plays, new data is kept
    wr(4'd0, 6'b0_00_100); wr(4'd1, 6'b0_00_101);
    bus.Start = 1'b1;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (c == 0) bus.Start = 1'b0;
      if (c < 4)       exp = {1'b1, 1'b1, 3'd4, 4'd0, 1'b0};
      else if (c < 6)  exp = {1'b1, 1'b0, 3'd4, 4'd0, 1'b0};
      else if (c < 10) exp = {1'b1, 1'b1, 3'd5, 4'd1, 1'b0};
      else if (c < 12) exp = {1'b1, 1'b0, 3'd5, 4'd1, 1'b0};
      else             exp = {1'b0, 1'b0, 3'd5, 4'd1, (c == 12)};
      obs = {bus.Busy, bus.Tone_en, bus.Tone_sel, bus.Note_idx, bus.Done};
      checks++;
      if (obs !== exp) begin fails++; $display("FAIL fetch_edge_write c=%0d got=%b exp=%b", c, obs, exp); end
      if (c == 5) begin bus.Wr_en = 1'b1; bus.Wr_addr = 4'd1; bus.Wr_data = 6'b0_01_110; end
      if (c == 6) bus.Wr_en = 1'b0;
    end

    bus.Start = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c == 0) bus.Start = 1'b0;
      if (c == 6) begin
        exp = {1'b1, 1'b1, 3'd6, 4'd1, 1'b0};
        obs = {bus.Busy, bus.Tone_en, bus.Tone_sel, bus.Note_idx, bus.Done};
        checks++;
        if (obs !== exp) begin fails++; $display("FAIL write_persisted got=%b exp=%b", obs, exp); end
      end
    end
    bus.Stop = 1'b1; tick(); bus.Stop = 1'b0; tick();
  endtask

  task automatic test_no_gap();
    wr0(4'd0, 6'b0_00_001); wr0(4'd1, 6'b0_00_110);
    bus0.Last_idx = 4'd1; bus0.Loop = 1'b0;
    bus0.Start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 0) bus0.Start = 1'b0;
      if (c < 4)      exp = {1'b1, 1'b1, 3'd1, 4'd0, 1'b0};
      else if (c < 8) exp = {1'b1, 1'b1, 3'd6, 4'd1, 1'b0};
      else            exp = {1'b0, 1'b0, 3'd6, 4'd1, (c == 8)};
      obs = {bus0.Busy, bus0.Tone_en, bus0.Tone_sel, bus0.Note_idx, bus0.Done};
      checks++;
      if (obs !== exp) begin fails++; $display("FAIL no_gap c=%0d got=%b exp=%b", c, obs, exp); end
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    bus.Wr_en = 1'b0; bus.Wr_addr = '0; bus.Wr_data = '0; bus.Last_idx = '0;
    bus.Loop = 1'b0; bus.Start = 1'b0; bus.Stop = 1'b0;
    bus0.Wr_en = 1'b0; bus0.Wr_addr = '0; bus0.Wr_data = '0; bus0.Last_idx = '0;
    bus0.Loop = 1'b0; bus0.Start = 1'b0; bus0.Stop = 1'b0;
    repeat (2) tick();

    test_reset();
    test_basic();
    test_rest_loop();
    test_stop_start();
    test_live_write();
    test_no_gap();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
